// File: rtl/priority_encoder_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_seq_if
// Description : Request/issue bundle for priority_encoder_seq.
// Revision    : 1.0
// ============================================================================
interface priority_encoder_seq_if #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) ();
    logic [N-1:0]     req;
    logic             flush;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_ovf;

    modport master (
        output req,
        output flush,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  out_ovf
    );

    modport slave (
        input  req,
        input  flush,
        input  out_ready,
        output out_valid,
        output out_idx,
        output out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/priority_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_seq
// Description : Pending-request store with a one-entry issue slot; fixed
//               priority, or round-robin when PRIORITY_ENCODER_SEQ_RR_EN is set.
// Revision    : 1.0
// ============================================================================
module priority_encoder_seq #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    priority_encoder_seq_if.slave       bus
);

    generate
        if ((N < 2) || (IDX_W != $clog2(N))) begin : g_param_check
            $error("priority_encoder_seq: N must be >= 2 and IDX_W == clog2(N)");
        end
    endgenerate

    logic [N-1:0]     r_pend;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic             r_ovf;

    logic [N-1:0]     w_eff;
    logic             w_load;
    logic             w_found;
    logic [IDX_W-1:0] w_sel;
    logic [N-1:0]     w_sel_oh;
    logic             w_merge;

    assign w_eff   = r_pend | bus.req;
    assign w_load  = !r_valid || bus.out_ready;
    assign w_merge = |(bus.req & r_pend);

`ifdef PRIORITY_ENCODER_SEQ_RR_EN
    logic [IDX_W-1:0] r_ptr;

    // Search begins one below the last winner and walks downward with wrap.
    always_comb begin
        int               v_start;
        int               v_calc;
        logic [IDX_W-1:0] v_pos;
        w_found  = 1'b0;
        w_sel    = '0;
        w_sel_oh = '0;
        v_start  = (r_ptr == '0) ? (N - 1) : (int'(r_ptr) - 1);
        v_calc   = 0;
        v_pos    = '0;
        for (int k = 0; k < N; k++) begin
            v_calc = v_start - k;
            if (v_calc < 0) begin
                v_calc = v_calc + N;
            end
            v_pos = IDX_W'(v_calc);
            if (!w_found && w_eff[v_pos]) begin
                w_found         = 1'b1;
                w_sel           = v_pos;
                w_sel_oh[v_pos] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (!bus.flush && w_load && w_found) begin
            r_ptr <= w_sel;
        end
    end
`else
    always_comb begin
        w_found  = 1'b0;
        w_sel    = '0;
        w_sel_oh = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (!w_found && w_eff[k]) begin
                w_found     = 1'b1;
                w_sel       = k[IDX_W-1:0];
                w_sel_oh[k] = 1'b1;
            end
        end
    end
`endif

    // While the slot is stalled, new requests (including the held line) accumulate in r_pend.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
        end else if (bus.flush) begin
            r_pend  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= w_merge;
            if (w_load) begin
                if (w_found) begin
                    r_valid <= 1'b1;
                    r_idx   <= w_sel;
                    r_pend  <= w_eff & ~w_sel_oh;
                end else begin
                    r_valid <= 1'b0;
                    r_pend  <= '0;
                end
            end else begin
                r_pend <= w_eff;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_idx   = r_idx;
    assign bus.out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_encoder_seq
// Description : Directed scoreboard bench for priority_encoder_seq (N=8).
// Revision    : 1.0
// ============================================================================
module tb_priority_encoder_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    priority_encoder_seq_if #(.N(8), .IDX_W(3)) dut_if ();

    priority_encoder_seq #(.N(8), .IDX_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accepted transfers are popped against the expected issue order.
    always @(negedge clk) begin
        if (rst_n && !dut_if.flush && dut_if.out_valid && dut_if.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got idx %0d expected no output", dut_if.out_idx);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (dut_if.out_idx !== e) begin
                    errors++;
                    $display("FAIL issue_idx: got %0d expected %0d", dut_if.out_idx, e);
                end
            end
        end
    end

    task automatic do_reset(input string name);
        rst_n            = 1'b0;
        dut_if.flush     = 1'b0;
        dut_if.req       = 8'hFF;
        dut_if.out_ready = 1'b1;
        tick();
        tick();
        check({name, "_valid"}, 32'(dut_if.out_valid), 32'd0);
        check({name, "_idx"},   32'(dut_if.out_idx),   32'd0);
        check({name, "_ovf"},   32'(dut_if.out_ovf),   32'd0);
        rst_n            = 1'b1;
        dut_if.req       = 8'h00;
        dut_if.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        dut_if.req       = 8'h00;
        dut_if.flush     = 1'b0;
        dut_if.out_ready = 1'b0;

        do_reset("reset");

        // Two lines in one pulse drain highest first.
        dut_if.out_ready = 1'b1;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd5);
        dut_if.req = 8'hA0;
        tick();
        check("a0_ovf0", 32'(dut_if.out_ovf), 32'd0);
        dut_if.req = 8'h00;
        tick();
        check("a0_ovf1", 32'(dut_if.out_ovf), 32'd0);
        tick();
        check("a0_idle", 32'(dut_if.out_valid), 32'd0);

        // Backpressure holds the slot even against a higher-priority arrival.
        do_reset("reset2");
        dut_if.req = 8'h04;
        tick();
        dut_if.req = 8'h40;
        tick();
        dut_if.req = 8'h00;
        check("bp_valid", 32'(dut_if.out_valid), 32'd1);
        check("bp_hold0", 32'(dut_if.out_idx), 32'd2);
        tick();
        check("bp_hold1", 32'(dut_if.out_idx), 32'd2);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd6);
        dut_if.out_ready = 1'b1;
        tick();
        dut_if.out_ready = 1'b0;
        check("bp_next", 32'(dut_if.out_idx), 32'd6);
        dut_if.out_ready = 1'b1;
        tick();
        check("bp_idle", 32'(dut_if.out_valid), 32'd0);

        // Repeated request on a stalled line merges and re-services.
        do_reset("reset3");
        dut_if.req = 8'h08;
        tick();
        check("ovf_slot", 32'(dut_if.out_idx), 32'd3);
        check("ovf_e1", 32'(dut_if.out_ovf), 32'd0);
        tick();
        check("ovf_e2", 32'(dut_if.out_ovf), 32'd0);
        tick();
        check("ovf_e3", 32'(dut_if.out_ovf), 32'd1);
        dut_if.req = 8'h00;
        tick();
        check("ovf_e4", 32'(dut_if.out_ovf), 32'd0);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd3);
        dut_if.out_ready = 1'b1;
        tick();
        tick();
        check("ovf_idle", 32'(dut_if.out_valid), 32'd0);

        // All lines held: fixed build repeats 7, round-robin rotates.
        do_reset("reset4");
        dut_if.out_ready = 1'b1;
`ifdef PRIORITY_ENCODER_SEQ_RR_EN
        for (int j = 0; j < 8; j++) exp_q.push_back(3'(7 - j));
        exp_q.push_back(3'd7);
`else
        for (int j = 0; j < 9; j++) exp_q.push_back(3'd7);
`endif
        for (int j = 6; j >= 0; j--) exp_q.push_back(3'(j));
        dut_if.req = 8'hFF;
        for (int j = 1; j <= 9; j++) begin
            tick();
            check($sformatf("ff_ovf%0d", j), 32'(dut_if.out_ovf), (j >= 2) ? 32'd1 : 32'd0);
        end
        dut_if.req = 8'h00;
        tick();
        check("ff_ovf_end", 32'(dut_if.out_ovf), 32'd0);
        for (int j = 0; j < 7; j++) tick();
        check("ff_idle", 32'(dut_if.out_valid), 32'd0);

        // Flush drops slot and pending; req bit 4 overlaps P so ovf would fire without flush.
        do_reset("reset5");
        dut_if.req = 8'h80;
        tick();
        dut_if.req = 8'h30;
        tick();
        check("fl_slot", 32'(dut_if.out_idx), 32'd7);
        dut_if.flush = 1'b1;
        dut_if.req   = 8'h11;
        tick();
        check("fl_valid", 32'(dut_if.out_valid), 32'd0);
        check("fl_idx",   32'(dut_if.out_idx),   32'd7);
        check("fl_ovf",   32'(dut_if.out_ovf),   32'd0);
        dut_if.flush     = 1'b0;
        dut_if.req       = 8'h00;
        dut_if.out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check($sformatf("fl_empty%0d", j), 32'(dut_if.out_valid), 32'd0);
        end

        // Reset mid-transfer wins over flush and clears the index.
        dut_if.out_ready = 1'b0;
        dut_if.req       = 8'hC0;
        tick();
        check("mid_slot", 32'(dut_if.out_idx), 32'd7);
        dut_if.req       = 8'h00;
        rst_n            = 1'b0;
        dut_if.flush     = 1'b1;
        dut_if.out_ready = 1'b1;
        tick();
        check("mid_valid", 32'(dut_if.out_valid), 32'd0);
        check("mid_idx",   32'(dut_if.out_idx),   32'd0);
        rst_n        = 1'b1;
        dut_if.flush = 1'b0;
        tick();
        tick();
        check("mid_dropped", 32'(dut_if.out_valid), 32'd0);

        for (int j = 0; j < 20 && exp_q.size() != 0; j++) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/priority_encoder_seq.md
PRIORITY_ENCODER_SEQ -- requirements
Module: priority_encoder_seq

Interface
REQ-001 Parameter N, default 8, number of request lines (N >= 2).
REQ-002 Parameter IDX_W, default 3, index width; SHALL equal ceil(log2(N)).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  N  request pulses; bit i requests service for line i.
REQ-006 flush  input  1  synchronous clear of all pending and issued requests.
REQ-007 out_ready  input  1  consumer accepts the current output this cycle.
REQ-008 out_valid  output  1  output slot holds an issued request.
REQ-009 out_idx  output  IDX_W  binary index of the issued line.
REQ-010 out_ovf  output  1  one-cycle pulse indicating a request was merged into an already-pending bit.

Function
REQ-011 Internal pending register P[N-1:0] SHALL hold lines that have been requested but not yet issued.
REQ-012 Each cycle: eff = P | req; load L = !out_valid || out_ready.
REQ-013 If L and eff != 0: out_valid <= 1, out_idx <= sel(eff), P <= eff with bit sel(eff) cleared.
REQ-014 If L and eff == 0: out_valid <= 0, out_idx unchanged, P <= 0.
REQ-015 If !L: out_valid and out_idx SHALL hold, P <= eff.
REQ-016 Latency: req asserted before edge k on an idle block SHALL appear as out_valid=1 with its index after edge k.
REQ-017 While out_valid=1 and out_ready=0, out_idx SHALL NOT change, even if a higher-priority req arrives.
REQ-018 Fixed-priority sel(): highest set index wins (line N-1 highest, line 0 lowest).
REQ-019 A req on a line currently held in the output slot SHALL set its P bit (re-service); the request is not lost.
REQ-020 out_ovf SHALL be registered: high for exactly the cycle after any edge where (req & P) != 0; otherwise 0.
REQ-021 flush=1 SHALL, at the edge, set P <= 0 and out_valid <= 0, and ignore req that cycle; out_idx unchanged; out_ovf <= 0.
REQ-022 Indices >= N SHALL never be produced; when N is not a power of two, unused sel codes are unreachable.

Reset
REQ-023 rst_n=0 at an edge SHALL set P=0, out_valid=0, out_idx=0, out_ovf=0 (and RR pointer = 0 when compiled in); req, flush and out_ready are ignored.
REQ-024 Reset asserted mid-transfer SHALL drop the issued and pending requests with no acceptance.
REQ-025 Reset SHALL take precedence over flush.

Configuration
REQ-026 Macro PRIORITY_ENCODER_SEQ_RR_EN: when defined, sel() SHALL be round-robin using an IDX_W-bit pointer ptr.
REQ-027 With RR: search starts at line (ptr-1) mod N and proceeds downward, wrapping from 0 to N-1; the first set bit wins; on every load with eff != 0, ptr <= sel(eff).
REQ-028 With RR and ptr=0 (reset value), order equals fixed priority (N-1 first).
REQ-029 Without the macro: fixed priority per REQ-018; no pointer register exists.

Verification (N=8, IDX_W=3)
REQ-030 Reset: hold rst_n=0 with req=0xFF -> out_valid=0, out_idx=0, out_ovf=0.
REQ-031 req=0xA0 one cycle, out_ready=1 -> out_idx 7 then 5 on consecutive cycles, then out_valid=0; out_ovf stays 0.
REQ-032 Backpressure: out_ready=0; req=0x04, then req=0x40 -> out_idx holds 2; after out_ready=1 for one cycle -> out_idx=6.
REQ-033 Overflow: out_ready=0, req=0x08 held 3 cycles -> slot=3, P[3] set, then out_ovf=1 for exactly one cycle after the third edge.
REQ-034 req=0xFF held, out_ready=1 -> fixed build: out_idx 7 every cycle with out_ovf pulsing; RR build: 7,6,5,4,3,2,1,0,7.
REQ-035 Flush: P=0x30 with slot holding 7 and out_ready=0, assert flush with req=0x01 -> next cycle out_valid=0, P=0; line 0 not issued.
